// File: rtl/cla_pkg.sv
// Shared definitions for the chunked CLA operand front end.
//   CHUNK_W : bits handled per beat
//   chunk_t : one chunk of operand / propagate / carry bits
//   state_t : sequencer state
package cla_pkg;

    localparam int CHUNK_W = 5;

    typedef logic [CHUNK_W-1:0] chunk_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/cla_chunk_carry.sv
// Carry-lookahead network for one 5-bit chunk (purely combinational).
// Ports:
//   p   : per-bit propagate (a ^ b)
//   g   : per-bit generate  (a & b)
//   cin : carry into the chunk
//   c   : c[0] = cin, c[1..4] = carries into bits 1..4
//   k   : carry out of the chunk
module cla_chunk_carry
    import cla_pkg::*;
(
    input  chunk_t p,
    input  chunk_t g,
    input  logic   cin,
    output chunk_t c,
    output logic   k
);

    // Every carry is a flat sum of products of p/g/cin, so no carry
    // depends on a previously computed carry inside the chunk.
    always_comb begin
        c    = '0;
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        k    = g[4]
             | (p[4] & g[3])
             | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
    end

endmodule

// File: rtl/cla_pc_seq.sv
// Operand-side front end for the 5-bit CLA sum stage. Accepts one wide
// add/subtract request, then emits one beat per 5-bit chunk (LSB first)
// carrying the chunk's propagate bits and lookahead carries. The carry
// between chunks is chained through carry_reg.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake
//   in_a, in_b          : W-bit operands (W = 5*N_CHUNKS)
//   in_cin              : carry-in (add mode)
//   in_sub              : 1 = A - B (A + ~B + 1)
//   out_valid/out_ready : beat handshake
//   out_p, out_c        : chunk propagate bits / carries into each bit
//   out_idx             : chunk number, 0 = LSB chunk
//   out_last            : beat is the final chunk
//   out_cout            : carry-out of the whole operation (last beat only)
module cla_pc_seq
    import cla_pkg::*;
#(
    parameter int N_CHUNKS = 4,
    parameter int IDX_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*N_CHUNKS-1:0] in_a,
    input  logic [CHUNK_W*N_CHUNKS-1:0] in_b,
    input  logic                        in_cin,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHUNK_W-1:0]          out_p,
    output logic [CHUNK_W-1:0]          out_c,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        out_cout
);

    localparam int SEL_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    state_t state;
    state_t state_n;

    logic [N_CHUNKS-1:0][CHUNK_W-1:0] a_reg;
    logic [N_CHUNKS-1:0][CHUNK_W-1:0] b_reg;
    logic                             carry_reg;
    logic [IDX_W-1:0]                 idx;

    logic       accept;
    logic       beat_done;
    logic       is_last;
    logic [SEL_W-1:0] sel;
    chunk_t     a_cur;
    chunk_t     b_cur;
    chunk_t     p_cur;
    chunk_t     g_cur;
    chunk_t     c_cur;
    logic       k_cur;

    assign sel     = idx[SEL_W-1:0];
    assign a_cur   = a_reg[sel];
    assign b_cur   = b_reg[sel];
    assign p_cur   = a_cur ^ b_cur;
    assign g_cur   = a_cur & b_cur;
    assign is_last = (idx == IDX_W'(N_CHUNKS - 1));

    cla_chunk_carry u_carry (
        .p   (p_cur),
        .g   (g_cur),
        .cin (carry_reg),
        .c   (c_cur),
        .k   (k_cur)
    );

    assign accept    = (state == IDLE) && in_valid;
    assign beat_done = (state == RUN) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_p     = '0;
        out_c     = '0;
        out_last  = 1'b0;
        out_cout  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_p     = p_cur;
                out_c     = c_cur;
                out_last  = is_last;
                out_cout  = is_last & k_cur;
                if (out_ready && is_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_idx = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            // Subtraction is folded into the operands here so the run
            // phase only ever performs an add.
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub | in_cin;
            idx       <= '0;
        end else if (beat_done) begin
            if (is_last) begin
                idx <= '0;
            end else begin
                carry_reg <= k_cur;
                idx       <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cla_pc_seq.sv
// Self-checking bench for cla_pc_seq (N_CHUNKS = 4). Expected beats are
// derived arithmetically (carry into bit n = bit n of the sum of the low
// n bits) and queued when a request is driven; beats are popped and
// compared as the DUT emits them.
module tb_cla_pc_seq;

    localparam int NC = 4;
    localparam int W  = 5 * NC;

    typedef struct {
        logic [4:0] p;
        logic [4:0] c;
        logic [3:0] idx;
        logic       last;
        logic       cout;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_p;
    logic [4:0]   out_c;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         out_cout;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    cla_pc_seq #(
        .N_CHUNKS (NC),
        .IDX_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_c     (out_c),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pushes the expected beats for one request; returns the expected sum.
    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] sum);
        logic [W:0] aa, bb, mask, tot;
        logic       ci;
        beat_t      e;
        aa  = {1'b0, a};
        bb  = {1'b0, (sub ? ~b : b)};
        ci  = sub ? 1'b1 : cin;
        tot = aa + bb + {{W{1'b0}}, ci};
        sum = tot[W-1:0];
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < 5; j++) begin
                logic [W:0] part;
                int n;
                n    = 5 * i + j;
                mask = ({{W{1'b0}}, 1'b1} << n) - 1'b1;
                part = (aa & mask) + (bb & mask) + {{W{1'b0}}, ci};
                e.c[j] = part[n];
                e.p[j] = aa[n] ^ bb[n];
            end
            e.idx  = 4'(i);
            e.last = (i == NC - 1);
            e.cout = (i == NC - 1) ? tot[W] : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", 32'd0, 32'd1);
    endtask

    // One request. stall_idx: beat held with out_ready=0 for 3 cycles;
    // rst_idx: beat at which reset is pulsed; poke: drive a competing
    // in_valid during the run, which must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input int stall_idx, input int rst_idx, input bit poke);
        logic [W-1:0] exp_sum;
        logic [W-1:0] got_sum;
        beat_t        e;
        bit           ok;
        logic [4:0]   hp, hc;
        logic [3:0]   hi;

        push_expected(a, b, cin, sub, exp_sum);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (poke) begin
            in_a = ~a; in_b = a; in_cin = ~cin; in_sub = ~sub;
        end else begin
            in_valid = 1'b0;
        end
        got_sum = '0;

        for (int bi = 0; bi < NC; bi++) begin
            wait_valid(ok);
            if (!ok) begin
                sb.delete();
                in_valid = 1'b0;
                return;
            end
            if (bi == rst_idx) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_in_ready",  32'(in_ready),  32'd1);
                check("rst_out_idx",   32'(out_idx),   32'd0);
                check("rst_out_cout",  32'(out_cout),  32'd0);
                check("rst_out_pc",    {22'd0, out_p, out_c}, 32'd0);
                sb.delete();
                return;
            end
            if (bi == stall_idx) begin
                out_ready = 1'b0;
                hp = out_p; hc = out_c; hi = out_idx;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_p",     32'(out_p),     32'(hp));
                    check("stall_c",     32'(out_c),     32'(hc));
                    check("stall_idx",   32'(out_idx),   32'(hi));
                    check("stall_ready", 32'(in_ready),  32'd0);
                end
                out_ready = 1'b1;
            end
            e = sb.pop_front();
            check("beat_p",    32'(out_p),    32'(e.p));
            check("beat_c",    32'(out_c),    32'(e.c));
            check("beat_idx",  32'(out_idx),  32'(e.idx));
            check("beat_last", 32'(out_last), 32'(e.last));
            check("beat_cout", 32'(out_cout), 32'(e.cout));
            check("run_in_ready", 32'(in_ready), 32'd0);
            got_sum = got_sum | (W'(out_p ^ out_c) << (5 * bi));
            if (bi == NC - 1) in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        check("done_in_ready",  32'(in_ready),  32'd1);
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("sum",            32'(got_sum),   32'(exp_sum));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_idx",   32'(out_idx),   32'd0);
        check("reset_out_last",  32'(out_last),  32'd0);
        check("reset_out_cout",  32'(out_cout),  32'd0);
        check("reset_out_pc",    {22'd0, out_p, out_c}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(20'h00003, 20'h00005, 1'b0, 1'b0, -1, -1, 1'b0);
        run_op(20'h0001F, 20'h00001, 1'b0, 1'b0, -1, -1, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, -1, -1, 1'b0);
        run_op(20'h00005, 20'h00005, 1'b0, 1'b1, -1, -1, 1'b0);
        run_op(20'hFFFFF, 20'h00000, 1'b1, 1'b0, -1, -1, 1'b0);
        run_op(20'h00000, 20'h00001, 1'b0, 1'b1, -1, -1, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0,  1, -1, 1'b0);
        run_op(20'h12345, 20'h6789A, 1'b1, 1'b0, -1, -1, 1'b1);
        run_op(20'hABCDE, 20'h13579, 1'b0, 1'b0, -1,  2, 1'b0);
        run_op(20'h00000, 20'h00000, 1'b1, 1'b0, -1, -1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   (r == 3) ? 2 : -1, -1, (r == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
